// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit memory controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   // RV32I funct3 size/sign encodings; stores use only the first three.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LANES = 4;

   // True when funct3 names a supported access of the given direction.
   function automatic logic f3_legal(input logic store, input logic [2:0] f3);
      if (store) return f3 inside {F3_B, F3_H, F3_W};
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   // True when the byte offset does not match the access size.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return offset[0];
         2'b10:   return offset != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response channel to the core plus the byte-lane RAM port.
// The controller uses the slave view: it answers core requests and drives the RAM.
interface lsu_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 31,
   parameter int DATA_WIDTH = 31
);
   logic                  i_req_valid;
   logic                  o_req_ready;
   logic                  i_req_store;
   logic [2:0]            i_req_funct3;
   logic [31:0]           i_req_addr;
   logic [31:0]           i_req_wdata;
   logic                  o_resp_valid;
   logic [31:0]           o_resp_rdata;
   logic                  o_resp_misaligned;
   logic                  o_resp_illegal;
   logic                  o_mem_read_enable;
   logic [ADDR_WIDTH:0]   o_mem_read_addr;
   logic [DATA_WIDTH:0]   i_mem_read_data;
   logic [3:0]            o_mem_write_enable;
   logic [ADDR_WIDTH:0]   o_mem_write_addr;
   logic [DATA_WIDTH:0]   o_mem_write_data;

   modport slave (
      input  i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
      input  i_mem_read_data,
      output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned, o_resp_illegal,
      output o_mem_read_enable, o_mem_read_addr,
      output o_mem_write_enable, o_mem_write_addr, o_mem_write_data
   );

   modport master (
      output i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
      output i_mem_read_data,
      input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned, o_resp_illegal,
      input  o_mem_read_enable, o_mem_read_addr,
      input  o_mem_write_enable, o_mem_write_addr, o_mem_write_data
   );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// Turns a raw RAM word into the load result: undo lane ordering, pick the
// addressed byte/halfword/word and sign- or zero-extend it.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter bit READ_LANE_REVERSE = 1'b1
) (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] lanes;
   logic [31:0] shifted;

   // Byte lane k ends up in bits [8k+7:8k], then the addressed lane moves to bit 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      lanes   = word;
      result  = '0;
      if (READ_LANE_REVERSE) lanes = {word[7:0], word[15:8], word[23:16], word[31:24]};
      shifted = lanes >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {24'h0, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {16'h0, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the RV32I execute stage and the byte-lane RAM.
// One request in flight; all outputs come straight from flops.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH        = 31,
   parameter int DATA_WIDTH        = 31,
   parameter bit READ_LANE_REVERSE = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   lsu_mem_ctrl_if.slave   bus
);

   // Byte address widened or narrowed so bits above the RAM word address simply wrap.
   localparam int AEXT_W = ADDR_WIDTH + 3;

   state_t              state, state_nx;
   logic [AEXT_W-1:0]   addr_ext;
   logic [ADDR_WIDTH:0] word_addr;
   logic [1:0]          offset;
   logic                req_legal, req_misaligned, req_fault;
   logic [3:0]          we_enc;
   logic [DATA_WIDTH:0] wd_enc;
   logic                store_q;
   logic [2:0]          f3_q;
   logic [1:0]          off_q;
   logic [31:0]         load_result;

   assign addr_ext  = AEXT_W'(bus.i_req_addr);
   assign word_addr = addr_ext[AEXT_W-1:2];
   assign offset    = addr_ext[1:0];

   // Classify the incoming request; illegal funct3 masks the misaligned flag.
   always_comb begin
      req_legal      = f3_legal(bus.i_req_store, bus.i_req_funct3);
      req_misaligned = f3_misaligned(bus.i_req_funct3, offset);
      req_fault      = !req_legal || req_misaligned;
   end

   // Store lane enables and lane-replicated write data.
   always_comb begin
      we_enc = 4'b1111;
      wd_enc = bus.i_req_wdata;
      case (bus.i_req_funct3[1:0])
         2'b00: begin
            we_enc = 4'b0001 << offset;
            wd_enc = {LANES{bus.i_req_wdata[7:0]}};
         end
         2'b01: begin
            we_enc = offset[1] ? 4'b1100 : 4'b0011;
            wd_enc = {2{bus.i_req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Next-state logic: faults skip the RAM, stores skip the read wait.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.i_req_valid) state_nx = req_fault ? RESP : ISSUE;
         ISSUE:   state_nx = store_q ? RESP : WAIT;
         WAIT:    state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register, frozen while the shared clock enable is low.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst)        state <= IDLE;
      else if (clk_en) state <= state_nx;
   end

   // Registered outputs, captured request fields and RAM strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_q                <= 1'b0;
         f3_q                   <= '0;
         off_q                  <= '0;
         bus.o_req_ready        <= 1'b1;
         bus.o_resp_valid       <= 1'b0;
         bus.o_resp_rdata       <= '0;
         bus.o_resp_misaligned  <= 1'b0;
         bus.o_resp_illegal     <= 1'b0;
         bus.o_mem_read_enable  <= 1'b0;
         bus.o_mem_read_addr    <= '0;
         bus.o_mem_write_enable <= '0;
         bus.o_mem_write_addr   <= '0;
         bus.o_mem_write_data   <= '0;
      end else if (clk_en) begin
         bus.o_mem_read_enable  <= 1'b0;
         bus.o_mem_write_enable <= '0;
         bus.o_resp_valid       <= 1'b0;
         bus.o_req_ready        <= (state_nx == IDLE);
         case (state)
            IDLE: begin
               if (bus.i_req_valid) begin
                  store_q               <= bus.i_req_store;
                  f3_q                  <= bus.i_req_funct3;
                  off_q                 <= offset;
                  bus.o_resp_rdata      <= '0;
                  bus.o_resp_illegal    <= !req_legal;
                  bus.o_resp_misaligned <= req_legal && req_misaligned;
                  bus.o_resp_valid      <= req_fault;
                  if (!req_fault) begin
                     if (bus.i_req_store) begin
                        bus.o_mem_write_enable <= we_enc;
                        bus.o_mem_write_addr   <= word_addr;
                        bus.o_mem_write_data   <= wd_enc;
                     end else begin
                        bus.o_mem_read_enable  <= 1'b1;
                        bus.o_mem_read_addr    <= word_addr;
                     end
                  end
               end
            end
            ISSUE: bus.o_resp_valid <= store_q;
            WAIT: begin
               bus.o_resp_rdata <= load_result;
               bus.o_resp_valid <= 1'b1;
            end
            RESP: begin
               bus.o_resp_rdata      <= '0;
               bus.o_resp_illegal    <= 1'b0;
               bus.o_resp_misaligned <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   lsu_load_align #(
      .READ_LANE_REVERSE (READ_LANE_REVERSE)
   ) u_load_align (
      .word   (bus.i_mem_read_data),
      .offset (off_q),
      .funct3 (f3_q),
      .result (load_result)
   );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a lane-reversed byte RAM answers the controller,
// while a byte-array reference model predicts every response.
module tb_lsu_mem_ctrl;

   localparam int AW     = 5;
   localparam int NWORDS = 1 << (AW + 1);
   localparam int NBYTES = NWORDS * 4;

   logic clk = 1'b0;
   logic rst;
   logic clk_en;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(31)) bus ();

   lsu_mem_ctrl #(
      .ADDR_WIDTH        (AW),
      .DATA_WIDTH        (31),
      .READ_LANE_REVERSE (1'b1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .bus    (bus)
   );

   // RAM: lane k lives in bits [8k+7:8k]; reads return lane 0 in the top byte.
   logic [31:0] ram [NWORDS];
   logic [31:0] rdq = '0;
   assign bus.i_mem_read_data = rdq;

   always @(posedge clk) begin
      if (clk_en) begin
         for (int k = 0; k < 4; k++)
            if (bus.o_mem_write_enable[k])
               ram[bus.o_mem_write_addr][8*k +: 8] <= bus.o_mem_write_data[8*k +: 8];
         if (bus.o_mem_read_enable) begin
            rdq <= {ram[bus.o_mem_read_addr][7:0],   ram[bus.o_mem_read_addr][15:8],
                    ram[bus.o_mem_read_addr][23:16], ram[bus.o_mem_read_addr][31:24]};
         end
      end
   end

   // Strobe monitor: running totals plus the last strobe's fields.
   int          rd_total = 0;
   int          wr_total = 0;
   logic [3:0]  last_we;
   logic [31:0] last_wd;
   logic [AW:0] last_wa;
   logic [AW:0] last_ra;

   always @(negedge clk) begin
      if (bus.o_mem_read_enable) begin
         rd_total++;
         last_ra = bus.o_mem_read_addr;
      end
      if (bus.o_mem_write_enable != 4'b0000) begin
         wr_total++;
         last_we = bus.o_mem_write_enable;
         last_wd = bus.o_mem_write_data;
         last_wa = bus.o_mem_write_addr;
      end
   end

   // Reference memory, one entry per byte address.
   logic [7:0] ref_bytes [NBYTES];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit ref_legal(input bit st, input logic [2:0] f3);
      if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   // One complete transaction: predict, drive, wait for the response, compare.
   task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall, input string tag);
      bit          legal, mis, fault, got;
      int          size, exp_lat, lat, bi, off, rd0, wr0;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_we;
      logic [AW:0] exp_wa;

      legal   = ref_legal(st, f3);
      size    = acc_size(f3);
      mis     = legal && ((a & 32'(size - 1)) != 0);
      fault   = !legal || mis;
      bi      = int'(a[AW+2:0]);
      off     = bi % 4;
      exp_wa  = a[AW+2:2];
      exp_lat = fault ? 1 : (st ? 2 : 3 + stall);
      exp_rd  = '0;
      if (!st && !fault) begin
         for (int k = 0; k < size; k++) exp_rd = exp_rd | (32'(ref_bytes[bi + k]) << (8 * k));
         if (!f3[2] && size < 4 && exp_rd[8*size-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * size));
      end
      exp_we = '0;
      exp_wd = '0;
      for (int k = 0; k < 4; k++) begin
         exp_we[k]        = st && !fault && (k >= off) && (k < off + size);
         exp_wd[8*k +: 8] = wd[8*(k % size) +: 8];
      end

      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_req_ready) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, " ready before request"}, 32'(got), 32'd1);

      bus.i_req_valid  = 1'b1;
      bus.i_req_store  = st;
      bus.i_req_funct3 = f3;
      bus.i_req_addr   = a;
      bus.i_req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.i_req_valid  = 1'b0;
      bus.i_req_addr   = $urandom;
      bus.i_req_wdata  = $urandom;
      bus.i_req_funct3 = 3'($urandom_range(0, 7));
      rd0 = rd_total;
      wr0 = wr_total;

      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_resp_valid) begin
            got = 1'b1;
            break;
         end
         if (stall > 0 && lat == 2) begin
            clk_en = 1'b0;
            for (int s = 0; s < stall; s++) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
               check({tag, " frozen resp_valid"}, 32'(bus.o_resp_valid), 32'd0);
               check({tag, " frozen ready"}, 32'(bus.o_req_ready), 32'd0);
            end
            clk_en = 1'b1;
         end
         @(posedge clk);
         lat++;
      end
      check({tag, " response seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, bus.o_resp_rdata, exp_rd);
      check({tag, " misaligned"}, 32'(bus.o_resp_misaligned), 32'(mis));
      check({tag, " illegal"}, 32'(bus.o_resp_illegal), 32'(!legal));
      check({tag, " read strobes"}, 32'(rd_total - rd0), 32'(!st && !fault));
      check({tag, " write strobes"}, 32'(wr_total - wr0), 32'(st && !fault));
      if (st && !fault) begin
         check({tag, " write enable"}, 32'(last_we), 32'(exp_we));
         check({tag, " write data"}, last_wd, exp_wd);
         check({tag, " write addr"}, 32'(last_wa), 32'(exp_wa));
      end
      if (!st && !fault) check({tag, " read addr"}, 32'(last_ra), 32'(exp_wa));

      @(negedge clk);
      check({tag, " resp one cycle"}, 32'(bus.o_resp_valid), 32'd0);
      check({tag, " ready after resp"}, 32'(bus.o_req_ready), 32'd1);

      if (st && !fault)
         for (int k = 0; k < size; k++) ref_bytes[bi + k] = wd[8*k +: 8];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          st, any_resp;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [2:0]  leg_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      rst              = 1'b0;
      clk_en           = 1'b1;
      bus.i_req_valid  = 1'b0;
      bus.i_req_store  = 1'b0;
      bus.i_req_funct3 = '0;
      bus.i_req_addr   = '0;
      bus.i_req_wdata  = '0;
      for (int i = 0; i < NBYTES; i++) begin
         ref_bytes[i]              = 8'($urandom);
         ram[i / 4][8*(i % 4) +: 8] = ref_bytes[i];
      end

      #12;
      check("reset ready", 32'(bus.o_req_ready), 32'd1);
      check("reset resp_valid", 32'(bus.o_resp_valid), 32'd0);
      check("reset rdata", bus.o_resp_rdata, 32'd0);
      check("reset misaligned", 32'(bus.o_resp_misaligned), 32'd0);
      check("reset illegal", 32'(bus.o_resp_illegal), 32'd0);
      check("reset read enable", 32'(bus.o_mem_read_enable), 32'd0);
      check("reset write enable", 32'(bus.o_mem_write_enable), 32'd0);
      check("reset read addr", 32'(bus.o_mem_read_addr), 32'd0);
      check("reset write addr", 32'(bus.o_mem_write_addr), 32'd0);
      check("reset write data", bus.o_mem_write_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw 0x10");
      run_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, "sb 0x13");
      run_req(1'b0, 3'b000, 32'h13, 32'h0, 0, "lb 0x13");
      run_req(1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu 0x13");
      run_req(1'b1, 3'b010, 32'h20, 32'h80017FFF, 0, "sw 0x20");
      run_req(1'b0, 3'b001, 32'h22, 32'h0, 0, "lh 0x22");
      run_req(1'b0, 3'b101, 32'h20, 32'h0, 0, "lhu 0x20");
      run_req(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw 0x20");
      run_req(1'b1, 3'b001, 32'h26, 32'h00001234, 0, "sh 0x26");
      run_req(1'b0, 3'b010, 32'h24, 32'h0, 0, "lw 0x24");
      run_req(1'b0, 3'b010, 32'h21, 32'h0, 0, "lw misaligned");
      run_req(1'b0, 3'b001, 32'h23, 32'h0, 0, "lh misaligned");
      run_req(1'b1, 3'b010, 32'h22, 32'h55555555, 0, "sw misaligned");
      run_req(1'b0, 3'b011, 32'h21, 32'h0, 0, "load f3 011");
      run_req(1'b1, 3'b100, 32'h20, 32'h12345678, 0, "store f3 100");
      run_req(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw after faults");
      run_req(1'b0, 3'b010, 32'h10, 32'h0, 3, "lw clk_en stall");
      run_req(1'b0, 3'b010, 32'hABCDEF10, 32'h0, 0, "lw upper wrap");

      // Reset during the write strobe must abandon the store.
      run_req(1'b1, 3'b010, 32'h30, 32'h11223344, 0, "sw 0x30");
      @(negedge clk);
      bus.i_req_valid  = 1'b1;
      bus.i_req_store  = 1'b1;
      bus.i_req_funct3 = 3'b010;
      bus.i_req_addr   = 32'h30;
      bus.i_req_wdata  = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
      check("abort strobe before reset", 32'(bus.o_mem_write_enable), 32'hF);
      #2;
      rst = 1'b0;
      #1;
      check("abort write enable dropped", 32'(bus.o_mem_write_enable), 32'd0);
      check("abort resp_valid", 32'(bus.o_resp_valid), 32'd0);
      check("abort ready in reset", 32'(bus.o_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      any_resp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.o_resp_valid) any_resp = 1'b1;
      end
      check("abort no response", 32'(any_resp), 32'd0);
      check("abort ready after release", 32'(bus.o_req_ready), 32'd1);
      run_req(1'b0, 3'b010, 32'h30, 32'h0, 0, "lw 0x30 after abort");

      for (int n = 0; n < 150; n++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else f3 = st ? leg_f3[$urandom_range(0, 2)] : leg_f3[$urandom_range(0, 4)];
         a = $urandom;
         if ($urandom_range(0, 4) != 0) a = a & ~32'(acc_size(f3) - 1);
         run_req(st, f3, a, $urandom, st ? 0 : int'($urandom_range(0, 2)), $sformatf("rand %0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
